// File: rtl/alu_op_server_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_server_pkg
// Shared definitions for the ALU operation server: the 3-bit opcode map and
// the 2-bit FSM state encoding used by the top level.
// -----------------------------------------------------------------------------
package alu_op_server_pkg;

  // Opcode map; all eight codes are legal.
  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_SUB = 3'd1;
  localparam logic [2:0] OPC_AND = 3'd2;
  localparam logic [2:0] OPC_OR  = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_NOT = 3'd5;
  localparam logic [2:0] OPC_SHL = 3'd6;
  localparam logic [2:0] OPC_SHR = 3'd7;

  // Request/response sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : alu_op_server_pkg

// File: rtl/alu_op_core.sv
// -----------------------------------------------------------------------------
// alu_op_core
// Purely combinational ALU datapath.
// Ports:
//   a, b  [WIDTH]  operands
//   cin            carry-in / shift-in bit
//   opc   [3]      opcode (see alu_op_server_pkg)
//   w     [WIDTH]  result word
//   cout           carry-out (ADD/SUB) or shifted-out bit (SHL/SHR), else 0
//   zero           w == 0
// -----------------------------------------------------------------------------
module alu_op_core
  import alu_op_server_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] w,
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] b_arith_s;
  logic [WIDTH:0]   sum_s;

  // Shared adder: SUB reuses it with B inverted so cin=1 yields a - b and
  // the carry out reads as "no borrow".
  always_comb begin
    if (opc == OPC_SUB) begin
      b_arith_s = ~b;
    end else begin
      b_arith_s = b;
    end
    sum_s = {1'b0, a} + {1'b0, b_arith_s} + {{WIDTH{1'b0}}, cin};
  end

  // Result and carry selection by opcode.
  always_comb begin
    w    = {WIDTH{1'b0}};
    cout = 1'b0;
    case (opc)
      OPC_ADD, OPC_SUB: begin
        w    = sum_s[WIDTH-1:0];
        cout = sum_s[WIDTH];
      end
      OPC_AND: w = a & b;
      OPC_OR:  w = a | b;
      OPC_XOR: w = a ^ b;
      OPC_NOT: w = ~a;
      OPC_SHL: begin
        w    = {a[WIDTH-2:0], cin};
        cout = a[WIDTH-1];
      end
      OPC_SHR: begin
        w    = {cin, a[WIDTH-1:1]};
        cout = a[0];
      end
      default: begin
        w    = {WIDTH{1'b0}};
        cout = 1'b0;
      end
    endcase
  end

  assign zero = (w == {WIDTH{1'b0}});

endmodule : alu_op_core

// File: rtl/alu_op_server.sv
// -----------------------------------------------------------------------------
// alu_op_server
// Sequential responder for ALU requests. One {a, b, cin, opc} command is taken
// per req handshake, executed one cycle later, and the registered result is
// offered on the resp handshake until consumed.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      command handshake
//   req_a, req_b [WIDTH]       operands
//   req_cin, req_opc [3]       carry/shift-in bit, opcode
//   resp_valid / resp_ready    result handshake
//   resp_w [WIDTH]             result word
//   resp_cout, resp_zero       carry/shifted-out bit, result-is-zero flag
//   op_count [16]              completed responses, saturating
// Build option:
//   ALU_OP_SERVER_COUNT_EN     builds the response counter; otherwise
//                              op_count is tied to zero.
// -----------------------------------------------------------------------------
module alu_op_server
  import alu_op_server_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic [2:0]       req_opc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_w,
  output logic             resp_cout,
  output logic             resp_zero,
  output logic [15:0]      op_count
);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       opc_q, opc_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] core_w_s;
  logic             core_cout_s;
  logic             core_zero_s;

  alu_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .opc  (opc_q),
    .w    (core_w_s),
    .cout (core_cout_s),
    .zero (core_zero_s)
  );

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    opc_d   = opc_q;
    w_d     = w_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so the first cycle after reset
        // release (ready still low) never takes a command.
        if (req_ready_q && req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_cin;
          opc_d   = req_opc;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        w_d     = core_w_s;
        cout_d  = core_cout_s;
        zero_d  = core_zero_s;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the next state, so they depend
    // on state only and carry no combinational path from any input.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      cin_q        <= 1'b0;
      opc_q        <= 3'd0;
      w_q          <= {WIDTH{1'b0}};
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      opc_q        <= opc_d;
      w_q          <= w_d;
      cout_q       <= cout_d;
      zero_q       <= zero_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_w     = w_q;
  assign resp_cout  = cout_q;
  assign resp_zero  = zero_q;

`ifdef ALU_OP_SERVER_COUNT_EN
  logic [15:0] count_q, count_d;

  // Saturating count of response handshakes.
  always_comb begin
    if ((state_q == RESP) && resp_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign op_count = count_q;
`else
  assign op_count = 16'd0;
`endif

endmodule : alu_op_server

// File: tb/tb_alu_op_server.sv
// -----------------------------------------------------------------------------
// tb_alu_op_server
// Directed and randomized checks of alu_op_server (WIDTH=16) against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_op_server;
  import alu_op_server_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_cin;
  logic [2:0]  req_opc;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_w;
  logic        resp_cout;
  logic        resp_zero;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  alu_op_server #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_opc    (req_opc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_w     (resp_w),
    .resp_cout  (resp_cout),
    .resp_zero  (resp_zero),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {cout, w}, computed with plain integer arithmetic.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic [2:0] opc);
    int unsigned s;
    int unsigned ai, bi, ci;
    ai = a; bi = b; ci = cin;
    case (opc)
      3'd0: begin s = ai + bi + ci; return {s[16], s[15:0]}; end
      3'd1: begin s = ai + (32'hFFFF - bi) + ci; return {s[16], s[15:0]}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, 16'hFFFF - a};
      3'd6: begin s = (ai * 2 + ci) % 65536; return {a[15], s[15:0]}; end
      default: begin s = ai / 2 + ci * 32768; return {a[0], s[15:0]}; end
    endcase
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef ALU_OP_SERVER_COUNT_EN
    if (hs_count > 65535) return 16'hFFFF;
    return 16'(hs_count);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Request inputs are don't-care outside an accept; toggle them freely.
  task automatic scramble();
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_cin   = 1'($urandom);
    req_opc   = 3'($urandom);
    req_valid = 1'($urandom);
  endtask

  // One full transaction: accept, latency check, optional back-pressure, consume.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [2:0] opc, input int hold);
    logic [16:0] exp;
    exp = ref_alu(a, b, cin, opc);
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_opc = opc;
    @(posedge clk); #1;
    scramble();
    check("resp_valid_exec", 32'(resp_valid), 32'd0);
    check("req_ready_exec", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    scramble();
    check("resp_valid_latency", 32'(resp_valid), 32'd1);
    check("resp_w", 32'(resp_w), 32'(exp[15:0]));
    check("resp_cout", 32'(resp_cout), 32'(exp[16]));
    check("resp_zero", 32'(resp_zero), 32'(exp[15:0] == 16'd0));
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
      scramble();
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_w", 32'(resp_w), 32'(exp[15:0]));
      check("bp_resp_cout", 32'(resp_cout), 32'(exp[16]));
      check("bp_resp_zero", 32'(resp_zero), 32'(exp[15:0] == 16'd0));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    hs_count++;
    check("resp_valid_after_hs", 32'(resp_valid), 32'd0);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    check("op_count", 32'(op_count), 32'(exp_count()));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = 16'd0; req_b = 16'd0;
    req_cin = 1'b0; req_opc = 3'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_w", 32'(resp_w), 32'd0);
    check("rst_resp_cout", 32'(resp_cout), 32'd0);
    check("rst_resp_zero", 32'(resp_zero), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    do_op(16'hFFFF, 16'h0001, 1'b0, OPC_ADD, 0);
    do_op(16'h0005, 16'h0003, 1'b1, OPC_SUB, 0);
    do_op(16'h0003, 16'h0005, 1'b1, OPC_SUB, 0);
    do_op(16'h8001, 16'h0000, 1'b1, OPC_SHL, 0);
    do_op(16'h0001, 16'h0000, 1'b0, OPC_SHR, 0);
    do_op(16'hF0F0, 16'h0FF0, 1'b0, OPC_AND, 1);
    do_op(16'hF0F0, 16'h0FF0, 1'b0, OPC_OR, 0);
    do_op(16'hF0F0, 16'h0FF0, 1'b1, OPC_XOR, 0);
    do_op(16'hFFFF, 16'h1234, 1'b1, OPC_NOT, 0);
    // Back-pressure for 5 cycles with a non-zero result.
    do_op(16'h1234, 16'h4321, 1'b1, OPC_ADD, 5);

    // Reset while in EXEC: the command is dropped.
    req_valid = 1'b1; req_a = 16'hABCD; req_b = 16'h1111; req_cin = 1'b1; req_opc = OPC_ADD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_w", 32'(resp_w), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    hs_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    check("abort_req_ready_back", 32'(req_ready), 32'd1);

    // Ten back-to-back random commands.
    for (int i = 0; i < 10; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 0);
    end
    check("op_count_after_10", 32'(op_count), 32'(exp_count()));

    // Further random commands with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_op_server
